// File: rtl/lsu_pkg.sv
// Shared types and helpers for the LSU access sequencer.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (trap instead of split).
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE0  = 3'd1,
        ISSUE1  = 3'd2,
        COLLECT = 3'd3,
        RESP    = 3'd4
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0011;
    localparam logic [3:0] MASK_W = 4'b1111;

    function automatic logic [3:0] size_mask(input logic [2:0] f3);
        logic [3:0] m;
        if (f3[1])
            m = MASK_W;
        else if (f3[0])
            m = MASK_H;
        else
            m = MASK_B;
        return m;
    endfunction

    // Half splits only at offset 3; word splits at any nonzero offset.
    function automatic logic is_split(
        input logic [2:0] f3,
        input logic [1:0] off
    );
        logic s;
        if (f3[1])
            s = (off != 2'd0);
        else if (f3[0])
            s = (off == 2'd3);
        else
            s = 1'b0;
        return s;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane alignment: store shifter/strobes and load extract/extend.
// Purely combinational; the sequencer FSM lives in the top module.
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [2:0]        funct3,
    input  logic [1:0]        off,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] lo,
    input  logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] wdata_lo,
    output logic [DATA_W-1:0] wdata_hi,
    output logic [3:0]        strb_lo,
    output logic [3:0]        strb_hi,
    output logic [DATA_W-1:0] rdata
);

    logic [2*DATA_W-1:0] wsh;
    logic [2*DATA_W-1:0] rsh;
    logic [7:0]          msk;
    logic [4:0]          shamt;
    logic                sgn;

    assign shamt = {off, 3'b000};

    assign wsh = {{DATA_W{1'b0}}, wdata} << shamt;
    assign msk = {4'b0000, size_mask(funct3)} << off;
    assign rsh = {hi, lo} >> shamt;

    assign wdata_lo = wsh[DATA_W-1:0];
    assign wdata_hi = wsh[2*DATA_W-1:DATA_W];
    assign strb_lo  = msk[3:0];
    assign strb_hi  = msk[7:4];

    assign sgn = !funct3[2];

    always_comb begin
        rdata = '0;
        if (funct3[1])
            rdata = rsh[DATA_W-1:0];
        else if (funct3[0])
            rdata = {{(DATA_W-16){sgn & rsh[15]}}, rsh[15:0]};
        else
            rdata = {{(DATA_W-8){sgn & rsh[7]}}, rsh[7:0]};
    end

endmodule

// File: rtl/lsu_access_sequencer.sv
// MEM-stage load/store sequencer: one request -> one or two word beats.
// Define LSU_MISALIGN_TRAP_EN to flag misaligned accesses instead of splitting.
module lsu_access_sequencer
    import lsu_pkg::*;
#(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [DM_ADDRESS-1:0] req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  resp_valid,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic                  resp_misalign,
    output logic                  busy,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [DM_ADDRESS-1:0] mem_addr,
    output logic [3:0]            mem_wstrb,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata
);

    state_t state;
    state_t state_n;

    logic [DM_ADDRESS-1:0] addr_q;
    logic [2:0]            f3_q;
    logic                  we_q;
    logic [DATA_W-1:0]     wdata_q;
    logic                  split_q;
    logic [DATA_W-1:0]     lo_q;
    logic [DATA_W-1:0]     rdata_q;

    logic                  accept;
    logic                  split_in;
    logic [DM_ADDRESS-1:0] word0;
    logic [DM_ADDRESS-1:0] word1;

    logic [DATA_W-1:0]     ld_lo;
    logic [DATA_W-1:0]     ld_hi;
    logic [DATA_W-1:0]     wd_lo;
    logic [DATA_W-1:0]     wd_hi;
    logic [3:0]            sb_lo;
    logic [3:0]            sb_hi;
    logic [DATA_W-1:0]     ext;

    assign req_ready = (state == IDLE) && !reset;
    assign busy      = !req_ready;
    assign accept    = req_valid && req_ready;
    assign split_in  = is_split(req_funct3, req_addr[1:0]);

    assign word0 = {addr_q[DM_ADDRESS-1:2], 2'b00};
    assign word1 = word0 + DM_ADDRESS'(4);

    // Split loads pair the latched first word with the live second word.
    assign ld_lo = split_q ? lo_q : mem_rdata;
    assign ld_hi = split_q ? mem_rdata : '0;

    lsu_lane_align #(
        .DATA_W(DATA_W)
    ) u_align (
        .funct3  (f3_q),
        .off     (addr_q[1:0]),
        .wdata   (wdata_q),
        .lo      (ld_lo),
        .hi      (ld_hi),
        .wdata_lo(wd_lo),
        .wdata_hi(wd_hi),
        .strb_lo (sb_lo),
        .strb_hi (sb_hi),
        .rdata   (ext)
    );

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
`ifdef LSU_MISALIGN_TRAP_EN
                    state_n = split_in ? RESP : ISSUE0;
`else
                    state_n = ISSUE0;
`endif
                end
            end
            ISSUE0: begin
                if (split_q)
                    state_n = ISSUE1;
                else
                    state_n = we_q ? RESP : COLLECT;
            end
            ISSUE1:  state_n = we_q ? RESP : COLLECT;
            COLLECT: state_n = RESP;
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            addr_q  <= '0;
            f3_q    <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            split_q <= 1'b0;
            lo_q    <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                addr_q  <= req_addr;
                f3_q    <= req_funct3;
                we_q    <= req_we;
                wdata_q <= req_wdata;
                split_q <= split_in;
                rdata_q <= '0;
            end
            if (state == ISSUE1)
                lo_q <= mem_rdata;
            if (state == COLLECT)
                rdata_q <= ext;
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic mis_q;

    always_ff @(posedge clk) begin
        if (reset)
            mis_q <= 1'b0;
        else if (accept)
            mis_q <= split_in;
    end

    assign resp_misalign = mis_q;
`else
    assign resp_misalign = 1'b0;
`endif

    assign resp_valid = (state == RESP);
    assign resp_rdata = rdata_q;

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wstrb = '0;
        mem_wdata = '0;
        unique case (state)
            ISSUE0: begin
                mem_en    = 1'b1;
                mem_we    = we_q;
                mem_addr  = word0;
                mem_wstrb = we_q ? sb_lo : 4'b0000;
                mem_wdata = we_q ? wd_lo : '0;
            end
            ISSUE1: begin
                mem_en    = 1'b1;
                mem_we    = we_q;
                mem_addr  = word1;
                mem_wstrb = we_q ? sb_hi : 4'b0000;
                mem_wdata = we_q ? wd_hi : '0;
            end
            default: begin
                mem_en = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_lsu_access_sequencer.sv
// Self-checking bench for lsu_access_sequencer with a word memory model.
// Honors LSU_MISALIGN_TRAP_EN when the design is built with it.
module tb_lsu_access_sequencer;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [8:0]  req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_misalign;
    logic        busy;
    logic        mem_en;
    logic        mem_we;
    logic [8:0]  mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    lsu_access_sequencer #(
        .DM_ADDRESS(9),
        .DATA_W    (32)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_funct3   (req_funct3),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_misalign(resp_misalign),
        .busy         (busy),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wstrb    (mem_wstrb),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit mon_on = 1'b0;
    bit trap_mode = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Word memory: read data appears the cycle after a read beat.
    logic [31:0] mem [0:127];
    logic [31:0] rd_q;

    always @(posedge clk) begin
        if (mem_en === 1'b1) begin
            if (mem_we) begin
                for (int k = 0; k < 4; k++)
                    if (mem_wstrb[k])
                        mem[mem_addr[8:2]][8*k +: 8] <= mem_wdata[8*k +: 8];
            end else begin
                rd_q <= mem[mem_addr[8:2]];
            end
        end
    end

    assign mem_rdata = rd_q;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [8:0]  addr;
        logic [31:0] wdata;
        int          nb;
        logic [8:0]  a0;
        logic [3:0]  s0;
        logic [31:0] d0;
        logic [8:0]  a1;
        logic [3:0]  s1;
        logic [31:0] d1;
        logic [31:0] rd;
    } vec_t;

    typedef struct {
        int          c;
        logic [8:0]  a;
        logic        we;
        logic [3:0]  s;
        logic [31:0] d;
    } bt_t;

    typedef struct {
        int          c;
        logic [31:0] rd;
        logic        mis;
    } rs_t;

    bt_t bq[$];
    rs_t rq[$];
    vec_t tv[21];

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endfunction

    function automatic void tmo(string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out waiting for DUT", nm);
    endfunction

    // Scoreboard consumers: every beat and every response must be expected.
    always @(negedge clk) begin
        bt_t b;
        rs_t r;
        if (mon_on) begin
            if (mem_en !== 1'b0) begin
                if (bq.size() == 0) begin
                    chk("beat_unexpected", 32'(mem_en), 32'd0);
                end else begin
                    b = bq.pop_front();
                    chk("beat_cycle", 32'(cyc), 32'(b.c));
                    chk("beat_addr", 32'(mem_addr), 32'(b.a));
                    chk("beat_we", 32'(mem_we), 32'(b.we));
                    chk("beat_wstrb", 32'(mem_wstrb), 32'(b.s));
                    chk("beat_wdata", mem_wdata, b.d);
                end
            end
            if (resp_valid !== 1'b0) begin
                if (rq.size() == 0) begin
                    chk("resp_unexpected", 32'(resp_valid), 32'd0);
                end else begin
                    r = rq.pop_front();
                    chk("resp_cycle", 32'(cyc), 32'(r.c));
                    chk("resp_rdata", resp_rdata, r.rd);
                    chk("resp_misalign", 32'(resp_misalign), 32'(r.mis));
                end
            end
        end
    end

    task automatic push_expect(input vec_t v, input int t);
        bt_t b;
        rs_t r;
        bit  sp;
        sp = (v.nb == 2);
        if (sp && trap_mode) begin
            r.c = t + 1;
            r.rd = 32'd0;
            r.mis = 1'b1;
            rq.push_back(r);
        end else begin
            b.c = t + 1;
            b.a = v.a0;
            b.we = v.we;
            b.s = v.s0;
            b.d = v.d0;
            bq.push_back(b);
            if (sp) begin
                b.c = t + 2;
                b.a = v.a1;
                b.s = v.s1;
                b.d = v.d1;
                bq.push_back(b);
            end
            r.c = t + (v.we ? 2 : 3) + (sp ? 1 : 0);
            r.rd = v.rd;
            r.mis = 1'b0;
            rq.push_back(r);
        end
    endtask

    task automatic drive(input vec_t v);
        req_valid  = 1'b1;
        req_we     = v.we;
        req_funct3 = v.f3;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
    endtask

    task automatic issue(input vec_t v);
        int g;
        @(negedge clk);
        drive(v);
        g = 0;
        while (req_ready !== 1'b1 && g < 20) begin
            @(negedge clk);
            g++;
        end
        if (g >= 20) begin
            tmo("accept");
        end else begin
            push_expect(v, cyc);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        g = 0;
        while ((bq.size() != 0 || rq.size() != 0) && g < 20) begin
            @(negedge clk);
            g++;
        end
        if (g >= 20) begin
            tmo("drain");
            bq.delete();
            rq.delete();
        end
    endtask

    initial begin
        vec_t v;
        int   t;
`ifdef LSU_MISALIGN_TRAP_EN
        trap_mode = 1'b1;
`endif
        for (int i = 0; i < 128; i++) mem[i] = 32'd0;
        rd_q = 32'd0;

        tv[0]  = '{1'b1, F3_W, 9'h010, 32'h11223344, 1, 9'h010, 4'hF, 32'h11223344, 9'h0, 4'h0, 32'h0, 32'h0};
        tv[1]  = '{1'b1, F3_B, 9'h013, 32'h000000AB, 1, 9'h010, 4'h8, 32'hAB000000, 9'h0, 4'h0, 32'h0, 32'h0};
        tv[2]  = '{1'b1, F3_H, 9'h002, 32'h0000BEEF, 1, 9'h000, 4'hC, 32'hBEEF0000, 9'h0, 4'h0, 32'h0, 32'h0};
        tv[3]  = '{1'b1, F3_W, 9'h010, 32'h00FF0000, 1, 9'h010, 4'hF, 32'h00FF0000, 9'h0, 4'h0, 32'h0, 32'h0};
        tv[4]  = '{1'b0, F3_B, 9'h012, 32'h0, 1, 9'h010, 4'h0, 32'h0, 9'h0, 4'h0, 32'h0, 32'hFFFFFFFF};
        tv[5]  = '{1'b0, F3_BU, 9'h012, 32'h0, 1, 9'h010, 4'h0, 32'h0, 9'h0, 4'h0, 32'h0, 32'h000000FF};
        tv[6]  = '{1'b0, F3_H, 9'h011, 32'h0, 1, 9'h010, 4'h0, 32'h0, 9'h0, 4'h0, 32'h0, 32'hFFFFFF00};
        tv[7]  = '{1'b0, F3_HU, 9'h011, 32'h0, 1, 9'h010, 4'h0, 32'h0, 9'h0, 4'h0, 32'h0, 32'h0000FF00};
        tv[8]  = '{1'b1, F3_W, 9'h010, 32'hDDCCBBAA, 1, 9'h010, 4'hF, 32'hDDCCBBAA, 9'h0, 4'h0, 32'h0, 32'h0};
        tv[9]  = '{1'b1, F3_W, 9'h014, 32'h44332211, 1, 9'h014, 4'hF, 32'h44332211, 9'h0, 4'h0, 32'h0, 32'h0};
        tv[10] = '{1'b0, F3_W, 9'h011, 32'h0, 2, 9'h010, 4'h0, 32'h0, 9'h014, 4'h0, 32'h0, 32'h11DDCCBB};
        tv[11] = '{1'b0, F3_H, 9'h013, 32'h0, 2, 9'h010, 4'h0, 32'h0, 9'h014, 4'h0, 32'h0, 32'h000011DD};
        tv[12] = '{1'b0, 3'b011, 9'h014, 32'h0, 1, 9'h014, 4'h0, 32'h0, 9'h0, 4'h0, 32'h0, 32'h44332211};
        tv[13] = '{1'b0, 3'b111, 9'h010, 32'h0, 1, 9'h010, 4'h0, 32'h0, 9'h0, 4'h0, 32'h0, 32'hDDCCBBAA};
        tv[14] = '{1'b0, F3_B, 9'h010, 32'h0, 1, 9'h010, 4'h0, 32'h0, 9'h0, 4'h0, 32'h0, 32'hFFFFFFAA};
        tv[15] = '{1'b0, F3_H, 9'h012, 32'h0, 1, 9'h010, 4'h0, 32'h0, 9'h0, 4'h0, 32'h0, 32'hFFFFDDCC};
        tv[16] = '{1'b0, F3_HU, 9'h012, 32'h0, 1, 9'h010, 4'h0, 32'h0, 9'h0, 4'h0, 32'h0, 32'h0000DDCC};
        tv[17] = '{1'b1, F3_H, 9'h1FF, 32'h0000BEEF, 2, 9'h1FC, 4'h8, 32'hEF000000, 9'h000, 4'h1, 32'h000000BE, 32'h0};
        tv[18] = '{1'b1, F3_W, 9'h016, 32'hCAFEF00D, 2, 9'h014, 4'hC, 32'hF00D0000, 9'h018, 4'h3, 32'h0000CAFE, 32'h0};
        tv[19] = '{1'b0, F3_W, 9'h016, 32'h0, 2, 9'h014, 4'h0, 32'h0, 9'h018, 4'h0, 32'h0, 32'hCAFEF00D};
        tv[20] = '{1'b0, F3_W, 9'h010, 32'h0, 1, 9'h010, 4'h0, 32'h0, 9'h0, 4'h0, 32'h0, 32'hDDCCBBAA};

        reset      = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 9'h0;
        req_wdata  = 32'h0;
        repeat (3) @(negedge clk);

        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_misalign", 32'(resp_misalign), 32'd0);

        reset  = 1'b0;
        mon_on = 1'b1;
        @(negedge clk);
        chk("idle_req_ready", 32'(req_ready), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 20; i++) issue(tv[i]);

        // Reset lands while a split load is in its second beat.
        @(negedge clk);
        v = tv[10];
        drive(v);
        chk("mid_req_ready", 32'(req_ready), 32'd1);
        t = cyc;
        if (trap_mode) begin
            push_expect(v, t);
        end else begin
            bt_t b;
            b.c = t + 1;
            b.a = 9'h010;
            b.we = 1'b0;
            b.s = 4'h0;
            b.d = 32'h0;
            bq.push_back(b);
            b.c = t + 2;
            b.a = 9'h014;
            bq.push_back(b);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_mem_en", 32'(mem_en), 32'd0);
        chk("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_req_ready", 32'(req_ready), 32'd1);
        chk("post_rst_busy", 32'(busy), 32'd0);
        repeat (6) @(negedge clk);
        chk("post_rst_beats_left", 32'(bq.size()), 32'd0);
        chk("post_rst_resp_left", 32'(rq.size()), 32'd0);
        bq.delete();
        rq.delete();

        issue(tv[20]);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/lsu_access_sequencer.md
Name: lsu_access_sequencer

Overview:
- MEM-stage initiator that converts one pipeline load/store request (funct3, byte address, store data) into one or two word accesses on a word-wide data-memory port.
- Generates byte-lane write strobes and aligned write data for stores; extracts and sign/zero-extends load data.
- Splits misaligned halfword/word accesses into two consecutive word beats.
- Sits between the EX/MEM register and the word data memory; uses a valid/ready handshake so the hazard unit can stall the pipeline.

Parameters:
- DM_ADDRESS, 9, byte-address width into data memory.
- DATA_W, 32, data width; only 32 is supported.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  instruction bits 14:12.
- req_addr  in  DM_ADDRESS  byte address.
- req_wdata  in  DATA_W  store data (rs2).
- resp_valid  out  1  one-cycle pulse: access complete.
- resp_rdata  out  DATA_W  extended load result; 0 for stores.
- resp_misalign  out  1  misalignment flag, qualified by resp_valid.
- busy  out  1  equals !req_ready; hazard-unit stall.
- mem_en  out  1  word-access strobe.
- mem_we  out  1  write enable; valid with mem_en.
- mem_addr  out  DM_ADDRESS  word-aligned address; bits 1:0 are always 0.
- mem_wstrb  out  4  byte-lane enables; lane k is byte offset k (little-endian).
- mem_wdata  out  DATA_W  lane-aligned write data.
- mem_rdata  in  DATA_W  read word; valid in the cycle after a read beat.

Behaviour:
- Size decode uses funct3[1:0]: 00 = byte, 01 = half, 1x = word. For loads, funct3[2] selects unsigned (LBU/LHU). Load funct3 011, 110 and 111 behave as LW.
- Offset off = req_addr[1:0]. An access is split when: half with off = 3; word with off != 0.
- Request capture: a request is accepted when req_valid && req_ready. Address, funct3, we and wdata are registered at acceptance.
- req_ready = (state == IDLE) && !reset.
- States: IDLE, ISSUE0, ISSUE1, COLLECT, RESP.
  - IDLE -> ISSUE0 on accept.
  - ISSUE0 drives word0 = {addr[DM_ADDRESS-1:2], 2'b00}. Next state: ISSUE1 if split; else COLLECT for a load, RESP for a store.
  - ISSUE1 drives word1 = word0 + 4, wrapping modulo 2^DM_ADDRESS. It also latches mem_rdata (the word0 data) into lo_q. Next state: COLLECT for a load, RESP for a store.
  - COLLECT registers the extracted result into resp_rdata. Source is {mem_rdata, lo_q} if split, else mem_rdata. Next state: RESP.
  - RESP asserts resp_valid for exactly one cycle. Next state: IDLE.
- Latency from accept at cycle T to resp_valid:
  - aligned store: T+2
  - split store: T+3
  - aligned load: T+3
  - split load: T+4
- Write path: form a 64-bit shift of {32'b0, wdata} << 8*off and an 8-bit mask of {size mask} << off. Size masks are 0001 (byte), 0011 (half), 1111 (word). The low 32 bits and 4 mask bits go to the ISSUE0 beat; the high halves go to the ISSUE1 beat.
- Read path: take the 64-bit {hi, lo} >> 8*off.
  - LB and LH sign-extend from bit 7 and bit 15 respectively.
  - LBU and LHU zero-extend.
- Memory outputs are combinational from state and capture registers. Outside ISSUE0 and ISSUE1, mem_en, mem_we and mem_wstrb are 0, and mem_addr and mem_wdata are 0.
- Reset values: state IDLE, resp_valid 0, resp_rdata 0, resp_misalign 0, lo_q 0. All mem_* outputs are 0.
- Reset mid-operation: the next cycle is IDLE with no further beats, no resp_valid, and the request is dropped. A first beat of a split store already issued is not rolled back.
- req_valid while busy is ignored. The requester must hold the request until it is accepted.

Optional Feature:
- Macro LSU_MISALIGN_TRAP_EN.
- Defined: a split-qualifying request issues no memory beat. The FSM goes IDLE -> RESP, so resp_valid is at T+1 with resp_misalign = 1 and resp_rdata = 0.
- Undefined: misaligned accesses are split as above, and resp_misalign is tied to 0.

Decomposition:
- Package lsu_pkg holds:
  - typedef enum state_t {IDLE, ISSUE0, ISSUE1, COLLECT, RESP}
  - funct3 constants F3_B = 000, F3_H = 001, F3_W = 010, F3_BU = 100, F3_HU = 101
  - size masks
  - a function is_split(funct3, off)
- One combinational sub-module, lsu_lane_align, contains the 64-bit store shifter and strobe generator plus the load extractor and extender. The FSM stays in the top module.

Test Plan:
- SW wdata 0x11223344 at addr 0x010 -> at T+1: mem_en = 1, mem_we = 1, mem_addr = 0x010, wstrb = 1111, wdata 0x11223344. resp_valid at T+2.
- SB wdata 0x000000AB at 0x013 -> wstrb = 1000, wdata 0xAB000000. SH 0xBEEF at 0x002 -> wstrb = 1100, wdata 0xBEEF0000.
- LB at 0x012 with mem_rdata 0x00FF0000 -> resp_rdata 0xFFFFFFFF at T+3. LBU at the same address -> 0x000000FF.
- LW at 0x011 with word 0x010 = 0xDDCCBBAA and word 0x014 = 0x44332211 -> beats at T+1 and T+2. resp_rdata 0x11DDCCBB at T+4.
- SH 0xBEEF at 0x1FF -> beat 0: addr 0x1FC, wstrb 1000, wdata 0xEF000000. Beat 1: addr 0x000 (wrap), wstrb 0001, wdata 0x000000BE. With LSU_MISALIGN_TRAP_EN: no mem_en, and resp_valid with resp_misalign = 1 at T+1.
- reset asserted during ISSUE1 of a split load -> next cycle mem_en = 0 and resp_valid never pulses. req_ready = 1 in the first cycle after reset is released, and a fresh aligned LW then completes at T+3.
